alu_sequencer: RTL

Command sequencer in front of the 8-bit flagged ALU datapath. It accepts ALU commands over a valid/ready handshake and drives the ALU operand, control and shift-amount inputs from registers. Each command can iterate the same operation up to 4 times, feeding the result back as operand A. It captures the final result and {C,V,N,Z} flags into a response register held until the consumer accepts it.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_CTRL_W = 3;
    localparam int DEFAULT_AMT_W  = 2;

    // Flag vector layout {C,V,N,Z}
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer driving an external flagged ALU; repeats an op up to 4 times.
// Optional ALU_SEQ_STICKY_FLAGS_EN: C and V in the response accumulate over all iterations.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int AMT_W  = DEFAULT_AMT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CTRL_W-1:0] cmd_op,
    input  logic [AMT_W-1:0]  cmd_amt,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic              cmd_chain,
    input  logic [1:0]        cmd_rep,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [AMT_W-1:0]  alu_amt,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              busy
);

    seq_state_e       state;
    logic [1:0]       rep_cnt;
    logic [WIDTH-1:0] last_result;
    logic [3:0]       final_flags;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic c_acc;
    logic v_acc;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        final_flags         = alu_flags;
        final_flags[FLAG_C] = alu_flags[FLAG_C] | c_acc;
        final_flags[FLAG_V] = alu_flags[FLAG_V] | v_acc;
    end
`else
    always_comb begin
        final_flags = alu_flags;
    end
`endif

    // Handshake and status decode straight from the state register.
    assign cmd_ready = ena && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
            alu_amt     <= '0;
            rep_cnt     <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            last_result <= '0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
            c_acc       <= 1'b0;
            v_acc       <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_ctrl <= cmd_op;
                        alu_amt  <= cmd_amt;
                        alu_b    <= cmd_b;
                        alu_a    <= cmd_chain ? last_result : cmd_a;
                        rep_cnt  <= cmd_rep;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                        c_acc    <= 1'b0;
                        v_acc    <= 1'b0;
`endif
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (rep_cnt != 2'd0) begin
                        // Feed the result back as operand A for the next iteration.
                        alu_a   <= alu_result;
                        rep_cnt <= rep_cnt - 2'd1;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                        c_acc   <= c_acc | alu_flags[FLAG_C];
                        v_acc   <= v_acc | alu_flags[FLAG_V];
`endif
                    end else begin
                        rsp_result  <= alu_result;
                        rsp_flags   <= final_flags;
                        last_result <= alu_result;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
